reconfig_shift_array: RTL and testbench

//   Parametrised LED pattern engine for the shift/count DFX design: NUM_CH independent

---
 rtl/reconfig_shift_array.sv | 148 ++++++++++++++
 tb/tb_reconfig_shift_array.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/reconfig_shift_array.sv
// Multi-channel LED pattern engine: per-channel hold/rotate/count modes stepped by a shared
// programmable prescaler, configured one channel at a time over a valid/ready handshake.
module reconfig_shift_array #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned CH_WIDTH  = 4,
   parameter int unsigned DIV_WIDTH = 24,
   parameter int unsigned CH_IDX_W  = 2
) (
   input  logic                         gclk,
   input  logic                         rst,
   input  logic                         run,
   input  logic [DIV_WIDTH-1:0]         div,
   input  logic                         cfg_valid,
   output logic                         cfg_ready,
   input  logic [CH_IDX_W-1:0]          cfg_ch,
   input  logic [1:0]                   cfg_mode,
   output logic [NUM_CH*CH_WIDTH-1:0]   leds,
   output logic                         step
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   localparam logic [1:0] ModeHold = 2'b00;
   localparam logic [1:0] ModeRotl = 2'b01;
   localparam logic [1:0] ModeRotr = 2'b10;
   localparam logic [1:0] ModeCnt  = 2'b11;

   state_e                 state_q, state_d;
   logic [DIV_WIDTH-1:0]   presc_q, presc_d;
   logic [DIV_WIDTH-1:0]   div_q, div_d;
   logic [DIV_WIDTH-1:0]   div_eff;
   logic                   load_q;
   logic                   step_q, step_d;
   logic                   ready_q, ready_d;
   logic                   run_en;
   logic                   step_fire;
   logic                   xfer;
   logic [CH_WIDTH-1:0]    val_q [NUM_CH];
   logic [CH_WIDTH-1:0]    val_d [NUM_CH];
   logic [1:0]             mode_q [NUM_CH];
   logic [1:0]             mode_d [NUM_CH];

   // State register
   always_ff @(posedge gclk) begin
      if (!rst) state_q <= StIdle;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (run)  state_d = StRun;
         StRun:   if (!run) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output decode
   always_comb begin
      run_en = 1'b0;
      unique case (state_q)
         StIdle:  run_en = 1'b0;
         StRun:   run_en = 1'b1;
         default: run_en = 1'b0;
      endcase
   end

   assign div_eff   = (div == '0) ? DIV_WIDTH'(1) : div;
   assign step_fire = run_en && (presc_q == div_q - DIV_WIDTH'(1));
   assign xfer      = cfg_valid && ready_q;

   // div_q only changes at a period boundary so a new divider never truncates a period
   always_comb begin
      presc_d = presc_q;
      div_d   = div_q;
      if (load_q) div_d = div_eff;
      if (run_en) begin
         if (step_fire) begin
            presc_d = '0;
            div_d   = div_eff;
         end else begin
            presc_d = presc_q + DIV_WIDTH'(1);
         end
      end
      step_d  = step_fire;
      ready_d = !xfer;
   end

   // A config seed on the same edge as a step takes priority over that channel's step
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         val_d[c]  = val_q[c];
         mode_d[c] = mode_q[c];
         if (step_fire) begin
            unique case (mode_q[c])
               ModeHold: val_d[c] = val_q[c];
               ModeRotl: val_d[c] = {val_q[c][CH_WIDTH-2:0], val_q[c][CH_WIDTH-1]};
               ModeRotr: val_d[c] = {val_q[c][0], val_q[c][CH_WIDTH-1:1]};
               ModeCnt:  val_d[c] = val_q[c] + CH_WIDTH'(1);
               default:  val_d[c] = val_q[c];
            endcase
         end
         if (xfer && (cfg_ch == CH_IDX_W'(c))) begin
            mode_d[c] = cfg_mode;
            unique case (cfg_mode)
               ModeHold: val_d[c] = val_q[c];
               ModeRotl: val_d[c] = CH_WIDTH'(1);
               ModeRotr: val_d[c] = CH_WIDTH'(1) << (CH_WIDTH - 1);
               ModeCnt:  val_d[c] = '0;
               default:  val_d[c] = val_q[c];
            endcase
         end
      end
   end

   always_ff @(posedge gclk) begin
      if (!rst) begin
         presc_q <= '0;
         div_q   <= DIV_WIDTH'(1);
         load_q  <= 1'b1;
         step_q  <= 1'b0;
         ready_q <= 1'b1;
         for (int c = 0; c < NUM_CH; c++) begin
            val_q[c]  <= '0;
            mode_q[c] <= ModeHold;
         end
      end else begin
         presc_q <= presc_d;
         div_q   <= div_d;
         load_q  <= 1'b0;
         step_q  <= step_d;
         ready_q <= ready_d;
         for (int c = 0; c < NUM_CH; c++) begin
            val_q[c]  <= val_d[c];
            mode_q[c] <= mode_d[c];
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : gen_leds
      assign leds[g*CH_WIDTH +: CH_WIDTH] = val_q[g];
   end

   assign step      = step_q;
   assign cfg_ready = ready_q;

endmodule

// File: tb/tb_reconfig_shift_array.sv
// Directed bench for reconfig_shift_array with three 4-bit channels and hand-computed
// expected LED patterns, step timing and handshake behaviour.
module tb_reconfig_shift_array;

   localparam int unsigned NUM_CH    = 3;
   localparam int unsigned CH_WIDTH  = 4;
   localparam int unsigned DIV_WIDTH = 8;
   localparam int unsigned CH_IDX_W  = 2;

   logic                       gclk = 1'b0;
   logic                       rst;
   logic                       run;
   logic [DIV_WIDTH-1:0]       div;
   logic                       cfg_valid;
   logic                       cfg_ready;
   logic [CH_IDX_W-1:0]        cfg_ch;
   logic [1:0]                 cfg_mode;
   logic [NUM_CH*CH_WIDTH-1:0] leds;
   logic                       step;

   int n_checks = 0;
   int n_pass   = 0;

   reconfig_shift_array #(
      .NUM_CH    (NUM_CH),
      .CH_WIDTH  (CH_WIDTH),
      .DIV_WIDTH (DIV_WIDTH),
      .CH_IDX_W  (CH_IDX_W)
   ) u_dut (
      .gclk      (gclk),
      .rst       (rst),
      .run       (run),
      .div       (div),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_mode  (cfg_mode),
      .leds      (leds),
      .step      (step)
   );

   always #5 gclk = ~gclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Outputs are sampled and inputs driven 1 time unit after the rising edge
   task automatic tick();
      @(posedge gclk);
      #1;
   endtask

   logic [3:0] rotl_exp [4];
   initial begin
      rotl_exp[0] = 4'h2;
      rotl_exp[1] = 4'h4;
      rotl_exp[2] = 4'h8;
      rotl_exp[3] = 4'h1;
   end

   initial begin
      rst       = 1'b0;
      run       = 1'b1;
      div       = 8'd3;
      cfg_valid = 1'b1;
      cfg_ch    = 2'd0;
      cfg_mode  = 2'b01;

      // Reset held with run and cfg_valid asserted
      repeat (3) tick();
      check("rst_leds", 32'(leds), 32'h000);
      check("rst_step", 32'(step), 32'd0);
      check("rst_ready", 32'(cfg_ready), 32'd1);
      rst       = 1'b1;
      run       = 1'b0;
      cfg_valid = 1'b0;
      tick();
      check("rel_leds0", 32'(leds), 32'h000);
      tick();
      check("rel_leds1", 32'(leds), 32'h000);

      // Rotate left on ch0, div=3
      cfg_valid = 1'b1;
      cfg_ch    = 2'd0;
      cfg_mode  = 2'b01;
      tick();
      cfg_valid = 1'b0;
      run       = 1'b1;
      check("rotl_seed", 32'(leds), 32'h001);
      check("rotl_ready0", 32'(cfg_ready), 32'd0);
      tick();
      check("rotl_ready1", 32'(cfg_ready), 32'd1);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("rotl_gap_a", 32'(step), 32'd0);
         tick();
         check("rotl_gap_b", 32'(step), 32'd0);
         tick();
         check("rotl_step", 32'(step), 32'd1);
         check("rotl_ch0", 32'(leds[3:0]), 32'(rotl_exp[k]));
      end

      // Count on ch1 with div=0; old period of 3 completes first
      cfg_valid = 1'b1;
      cfg_ch    = 2'd1;
      cfg_mode  = 2'b11;
      div       = 8'd0;
      tick();
      cfg_valid = 1'b0;
      check("cnt_seed", 32'(leds[7:4]), 32'h0);
      tick();
      check("cnt_nostep", 32'(step), 32'd0);
      tick();
      check("cnt_first", 32'(leds[7:4]), 32'h1);
      for (int k = 1; k <= 15; k++) begin
         tick();
         check("cnt_step", 32'(step), 32'd1);
         check("cnt_ch1", 32'(leds[7:4]), 32'((1 + k) % 16));
      end

      // Stop: the edge that sees run=0 still steps (ch1 0->1)
      run = 1'b0;
      tick();
      check("stop_ch1", 32'(leds[7:4]), 32'h1);
      tick();
      check("stop_step", 32'(step), 32'd0);

      // Handshake with cfg_valid held high
      cfg_valid = 1'b1;
      cfg_ch    = 2'd0;
      cfg_mode  = 2'b10;
      check("hs_ready_a", 32'(cfg_ready), 32'd1);
      tick();
      cfg_ch   = 2'd2;
      cfg_mode = 2'b01;
      check("hs_ready_b", 32'(cfg_ready), 32'd0);
      check("hs_ch0", 32'(leds[3:0]), 32'h8);
      tick();
      check("hs_ready_c", 32'(cfg_ready), 32'd1);
      check("hs_ch2_wait", 32'(leds[11:8]), 32'h0);
      tick();
      check("hs_ready_d", 32'(cfg_ready), 32'd0);
      check("hs_ch2", 32'(leds[11:8]), 32'h1);
      cfg_ch   = 2'd3;
      cfg_mode = 2'b11;
      tick();
      check("hs_ready_e", 32'(cfg_ready), 32'd1);
      tick();
      cfg_valid = 1'b0;
      check("hs_oor_ack", 32'(cfg_ready), 32'd0);
      check("hs_oor_leds", 32'(leds), 32'h118);

      // Collision: ch2 reconfigured on a step edge
      div = 8'd3;
      run = 1'b1;
      tick();
      check("col_enter", 32'(step), 32'd0);
      tick();
      check("col_step0", 32'(step), 32'd1);
      check("col_leds0", 32'(leds), 32'h224);
      tick();
      tick();
      check("col_gap", 32'(step), 32'd0);
      cfg_valid = 1'b1;
      cfg_ch    = 2'd2;
      cfg_mode  = 2'b10;
      tick();
      cfg_valid = 1'b0;
      check("col_step1", 32'(step), 32'd1);
      check("col_leds1", 32'(leds), 32'h832);

      // Freeze at presc=1 with div=4
      div = 8'd4;
      tick();
      tick();
      tick();
      check("frz_step", 32'(step), 32'd1);
      check("frz_leds", 32'(leds), 32'h441);
      run = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         tick();
         check("frz_hold_step", 32'(step), 32'd0);
         check("frz_hold_leds", 32'(leds), 32'h441);
      end
      run = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("frz_resume_gap", 32'(step), 32'd0);
      end
      tick();
      check("frz_resume_step", 32'(step), 32'd1);
      check("frz_resume_leds", 32'(leds), 32'h258);

      // Mid-period reset
      tick();
      rst = 1'b0;
      tick();
      check("mrst_leds", 32'(leds), 32'h000);
      check("mrst_step", 32'(step), 32'd0);
      check("mrst_ready", 32'(cfg_ready), 32'd1);
      rst = 1'b1;
      repeat (10) tick();
      check("mrst_hold_modes", 32'(leds), 32'h000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
